// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - multi-row pixel line buffer with staging prefetch and timed row advance
module window_line_buffer #(
    parameter int PIXEL_W = 24,
    parameter int ROWS    = 3,
    parameter int COLS    = 8,
    parameter int WIN     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_prime,
    input  logic                        start_prefetch,
    input  logic                        advance,
    input  logic [PIXEL_W-1:0]          pix_data,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [ROWS*WIN*PIXEL_W-1:0] window,
    output logic                        window_valid,
    output logic                        stage_full,
    output logic                        prime_done,
    output logic                        prefetch_done,
    output logic                        advance_done,
    output logic                        busy
);

    localparam int CNT_W = $clog2(ROWS*COLS+1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(ROWS*COLS-1);
    localparam logic [CNT_W-1:0] COLS_LAST  = CNT_W'(COLS-1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRIME    = 3'd1,
        S_READY    = 3'd2,
        S_PREFETCH = 3'd3,
        S_SHIFT    = 3'd4
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]   cnt;
    logic [PIXEL_W-1:0] line_q [ROWS][COLS];
    logic [PIXEL_W-1:0] stage_q [COLS];

    logic               acc;
    logic               prime_fin;
    logic               prefetch_fin;
    logic               shift_fin;
    logic               chain_en;
    logic [PIXEL_W-1:0] chain_src;
    logic               stage_load;
    logic               stage_drain;
    logic               stage_clr;

    assign acc          = pix_valid & pix_ready;
    assign prime_fin    = (state == S_PRIME)    && acc && (cnt == PRIME_LAST);
    assign prefetch_fin = (state == S_PREFETCH) && acc && (cnt == COLS_LAST);
    assign shift_fin    = (state == S_SHIFT)    && (cnt == COLS_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; READY resolves simultaneous commands prime > advance > prefetch
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_prime) next_state = S_PRIME;
            end
            S_PRIME: begin
                if (prime_fin) next_state = S_READY;
            end
            S_READY: begin
                if (start_prime)                       next_state = S_PRIME;
                else if (advance && stage_full)        next_state = S_SHIFT;
                else if (start_prefetch && !stage_full) next_state = S_PREFETCH;
            end
            S_PREFETCH: begin
                if (prefetch_fin) next_state = S_READY;
            end
            S_SHIFT: begin
                if (shift_fin) next_state = S_READY;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs and datapath strobes decoded from the current state
    always_comb begin
        pix_ready    = (state == S_PRIME) || (state == S_PREFETCH);
        window_valid = (state == S_READY) || (state == S_PREFETCH);
        busy         = (state == S_PRIME) || (state == S_PREFETCH) || (state == S_SHIFT);
        chain_en     = ((state == S_PRIME) && acc) || (state == S_SHIFT);
        chain_src    = (state == S_SHIFT) ? stage_q[COLS-1] : pix_data;
        stage_load   = (state == S_PREFETCH) && acc;
        stage_drain  = (state == S_SHIFT);
        stage_clr    = (state == S_READY) && start_prime;
    end

    // Step counter: restarts on every state change, so it never reaches past ROWS*COLS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (chain_en || stage_load) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Row chain: all rows form one long shift register, newest pixel at line[0][0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < COLS; j++) begin
                    line_q[r][j] <= '0;
                end
            end
        end else if (chain_en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = COLS-1; j > 0; j--) begin
                    line_q[r][j] <= line_q[r][j-1];
                end
            end
            line_q[0][0] <= chain_src;
            for (int r = 1; r < ROWS; r++) begin
                line_q[r][0] <= line_q[r-1][COLS-1];
            end
        end
    end

    // Staging buffer: fills from the pixel stream, drains its oldest entry into the rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < COLS; j++) begin
                stage_q[j] <= '0;
            end
        end else if (stage_clr) begin
            for (int j = 0; j < COLS; j++) begin
                stage_q[j] <= '0;
            end
        end else if (stage_load || stage_drain) begin
            for (int j = COLS-1; j > 0; j--) begin
                stage_q[j] <= stage_q[j-1];
            end
            stage_q[0] <= stage_load ? pix_data : '0;
        end
    end

    // Staging-full flag and one-cycle completion pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_full    <= 1'b0;
            prime_done    <= 1'b0;
            prefetch_done <= 1'b0;
            advance_done  <= 1'b0;
        end else begin
            if (stage_clr || shift_fin) begin
                stage_full <= 1'b0;
            end else if (prefetch_fin) begin
                stage_full <= 1'b1;
            end
            prime_done    <= prime_fin;
            prefetch_done <= prefetch_fin;
            advance_done  <= shift_fin;
        end
    end

    // Window packing: row 0 in the most significant slice, column 0 at the low end of each row
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar j = 0; j < WIN; j++) begin : g_col
            assign window[(ROWS-1-r)*WIN*PIXEL_W + j*PIXEL_W +: PIXEL_W] = line_q[r][j];
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - randomized self-checking bench for window_line_buffer
module tb_window_line_buffer;

    localparam int PW   = 24;
    localparam int ROWS = 3;
    localparam int COLS = 8;
    localparam int WIN  = 3;
    localparam int N    = ROWS*COLS;
    localparam int WW   = ROWS*WIN*PW;

    localparam int M_IDLE = 0, M_PRIME = 1, M_READY = 2, M_PREFETCH = 3, M_SHIFT = 4;

    localparam logic [WW-1:0] W_PRIME = {24'd22, 24'd23, 24'd24, 24'd14, 24'd15, 24'd16, 24'd6, 24'd7, 24'd8};
    localparam logic [WW-1:0] W_ADV   = {24'd106, 24'd107, 24'd108, 24'd22, 24'd23, 24'd24, 24'd14, 24'd15, 24'd16};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_prime = 1'b0;
    logic          start_prefetch = 1'b0;
    logic          advance = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [WW-1:0] window;
    logic          window_valid;
    logic          stage_full;
    logic          prime_done;
    logic          prefetch_done;
    logic          advance_done;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    window_line_buffer #(.PIXEL_W(PW), .ROWS(ROWS), .COLS(COLS), .WIN(WIN)) dut (
        .clk(clk), .rst(rst),
        .start_prime(start_prime), .start_prefetch(start_prefetch), .advance(advance),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .window(window), .window_valid(window_valid), .stage_full(stage_full),
        .prime_done(prime_done), .prefetch_done(prefetch_done), .advance_done(advance_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the rows are one flat shift chain, the staging buffer a plain array
    int            m_mode;
    int            m_cnt;
    logic [PW-1:0] m_chain [N];
    logic [PW-1:0] m_stage [COLS];
    bit            m_full, m_pd, m_fd, m_ad;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] m_window();
        logic [WW-1:0] w = '0;
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < WIN; j++)
                w[(ROWS-1-r)*WIN*PW + j*PW +: PW] = m_chain[r*COLS + j];
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_full = 0; m_pd = 0; m_fd = 0; m_ad = 0;
        for (int k = 0; k < N; k++) m_chain[k] = '0;
        for (int k = 0; k < COLS; k++) m_stage[k] = '0;
    endtask

    task automatic m_push(input logic [PW-1:0] v);
        for (int k = N-1; k > 0; k--) m_chain[k] = m_chain[k-1];
        m_chain[0] = v;
    endtask

    task automatic m_stage_in(input logic [PW-1:0] v);
        for (int k = COLS-1; k > 0; k--) m_stage[k] = m_stage[k-1];
        m_stage[0] = v;
    endtask

    task automatic model_step();
        bit acc;
        acc  = pix_valid && (m_mode == M_PRIME || m_mode == M_PREFETCH);
        m_pd = 0; m_fd = 0; m_ad = 0;
        case (m_mode)
            M_IDLE: if (start_prime) begin m_mode = M_PRIME; m_cnt = 0; end
            M_PRIME: if (acc) begin
                m_push(pix_data);
                m_cnt++;
                if (m_cnt == N) begin m_mode = M_READY; m_pd = 1; end
            end
            M_READY: begin
                if (start_prime) begin
                    m_mode = M_PRIME; m_cnt = 0; m_full = 0;
                    for (int k = 0; k < COLS; k++) m_stage[k] = '0;
                end else if (advance && m_full) begin
                    m_mode = M_SHIFT; m_cnt = 0;
                end else if (start_prefetch && !m_full) begin
                    m_mode = M_PREFETCH; m_cnt = 0;
                end
            end
            M_PREFETCH: if (acc) begin
                m_stage_in(pix_data);
                m_cnt++;
                if (m_cnt == COLS) begin m_full = 1; m_fd = 1; m_mode = M_READY; end
            end
            M_SHIFT: begin
                m_push(m_stage[COLS-1]);
                m_stage_in('0);
                m_cnt++;
                if (m_cnt == COLS) begin m_full = 0; m_ad = 1; m_mode = M_READY; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        check("pix_ready", WW'(pix_ready), WW'(m_mode == M_PRIME || m_mode == M_PREFETCH));
        check("window_valid", WW'(window_valid), WW'(m_mode == M_READY || m_mode == M_PREFETCH));
        check("busy", WW'(busy), WW'(m_mode == M_PRIME || m_mode == M_PREFETCH || m_mode == M_SHIFT));
        check("stage_full", WW'(stage_full), WW'(m_full));
        check("prime_done", WW'(prime_done), WW'(m_pd));
        check("prefetch_done", WW'(prefetch_done), WW'(m_fd));
        check("advance_done", WW'(advance_done), WW'(m_ad));
        check("window", window, m_window());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_window"}, window, '0);
        check({tag, "_outs"}, WW'({pix_ready, window_valid, stage_full, prime_done,
                                   prefetch_done, advance_done, busy}), '0);
    endtask

    // One clock: compare against the model, advance the model, release commands
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
        start_prime = 0; start_prefetch = 0; advance = 0;
    endtask

    task automatic send_px(input logic [PW-1:0] v, input int gap);
        pix_valid = 0;
        for (int g = 0; g < gap; g++) begin
            pix_data = PW'($urandom);
            cycle();
        end
        pix_valid = 1; pix_data = v;
        cycle();
        pix_valid = 0; pix_data = PW'($urandom);
    endtask

    task automatic prime_seq(input int gaps_wanted);
        int gaps [N];
        int idx;
        for (int k = 0; k < N; k++) gaps[k] = 0;
        for (int g = 0; g < gaps_wanted; g++) begin
            do idx = $urandom_range(0, N-1); while (gaps[idx] != 0);
            gaps[idx] = $urandom_range(1, 4);
        end
        start_prime = 1;
        cycle();
        for (int k = 1; k <= N; k++) send_px(PW'(k), gaps[k-1]);
    endtask

    task automatic prefetch_seq(input int base, input bit random_vals);
        start_prefetch = 1;
        cycle();
        for (int k = 1; k <= COLS; k++)
            send_px(random_vals ? PW'($urandom) : PW'(base + k), $urandom_range(0, 2));
    endtask

    task automatic count_shift(input string tag, input bit noisy);
        int k = 0;
        while (busy && k < 20) begin
            if (noisy) begin
                start_prime = 1'($urandom); start_prefetch = 1'($urandom); advance = 1'($urandom);
                pix_valid = 1'($urandom); pix_data = PW'($urandom);
            end
            k++;
            cycle();
        end
        pix_valid = 0;
        check({tag, "_cycles"}, WW'(k), WW'(COLS));
        check({tag, "_done"}, WW'(advance_done), WW'(1));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #3 rst = 0;

        // Prime 1..24 with pix_valid held high
        prime_seq(0);
        check("prime_done_pulse", WW'(prime_done), WW'(1));
        check("prime_window", window, W_PRIME);
        check("prime_status", WW'({window_valid, pix_ready}), WW'(2'b10));
        cycle();
        check("prime_done_once", WW'(prime_done), WW'(0));

        // Prefetch 101..108, then advance
        prefetch_seq(100, 0);
        check("prefetch_done_pulse", WW'(prefetch_done), WW'(1));
        check("prefetch_full", WW'(stage_full), WW'(1));
        check("prefetch_window", window, W_PRIME);
        advance = 1;
        cycle();
        count_shift("advance", 0);
        check("advance_window", window, W_ADV);
        check("advance_full", WW'(stage_full), WW'(0));

        // Illegal commands
        advance = 1;
        cycle();
        check("adv_empty_busy", WW'(busy), WW'(0));
        cycle();
        prefetch_seq(0, 1);
        start_prefetch = 1;
        cycle();
        check("prefetch_full_ignored", WW'(busy), WW'(0));
        advance = 1;
        cycle();
        count_shift("noisy_shift", 1);

        // Priority: prime beats advance with the stage full
        prefetch_seq(0, 1);
        start_prime = 1; advance = 1;
        cycle();
        check("prio_ready", WW'(pix_ready), WW'(1));
        check("prio_full", WW'(stage_full), WW'(0));
        for (int k = 0; k < N-1; k++) send_px(PW'($urandom), $urandom_range(0, 1));
        check("prio_not_done", WW'(window_valid), WW'(0));
        send_px(PW'($urandom), 0);
        check("prio_done", WW'(prime_done), WW'(1));
        cycle();

        // Backpressure: five random gaps during prime
        prime_seq(5);
        check("bp_window", window, W_PRIME);
        cycle();

        // Reset after 10 prime accepts
        start_prime = 1;
        cycle();
        for (int k = 1; k <= 10; k++) send_px(PW'(k), $urandom_range(0, 1));
        rst = 1;
        #1;
        check_all_zero("midrst");
        model_reset();
        #2 rst = 0;
        repeat (4) cycle();
        prime_seq(2);
        check("reprime_window", window, W_PRIME);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised multi-row pixel line buffer that feeds a ROWS×WIN pixel window to the cartoonifier filter datapath. Pixels arrive from the Avalon read master through a valid/ready handshake. An internal FSM sequences three operations: initial priming of all rows, background prefetch of the next column segment into a staging buffer, and a timed advance that cascades rows down by one segment. This block is the generalised successor of the fixed 3×8×24-bit read buffer. It adds explicit states, backpressure and done pulses.

## Interface
- PIXEL_W, 24, bits per pixel
- ROWS, 3, number of line registers (window height)
- COLS, 8, pixels held per line register and per staging buffer
- WIN, 3, window width in pixels; legal range 1 ≤ WIN ≤ COLS
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start_prime  in  1  single-cycle command: fill all rows
- start_prefetch  in  1  single-cycle command: fill the staging buffer
- advance  in  1  single-cycle command: shift the staging buffer into the rows
- pix_data  in  PIXEL_W  incoming pixel
- pix_valid  in  1  pix_data is valid
- pix_ready  out  1  block accepts a pixel this cycle
- window  out  ROWS*WIN*PIXEL_W  current window
- window_valid  out  1  window contents are stable and usable
- stage_full  out  1  staging buffer holds COLS pixels
- prime_done, prefetch_done, advance_done  out  1 each  one-cycle completion pulses
- busy  out  1  state is not IDLE or READY

## Operation
- **Storage.** line[r][j], with r in 0..ROWS-1 and j in 0..COLS-1; stage[j]. Position 0 holds the newest pixel.
- **Accept.** acc = pix_valid & pix_ready. pix_ready = 1 only in PRIME and PREFETCH.
- **Row chain shift**, used by PRIME and SHIFT:
  - line[r][j] <= line[r][j-1] for j>0.
  - line[0][0] <= the source pixel.
  - line[r][0] <= line[r-1][COLS-1] for r>0.
  - line[ROWS-1][COLS-1] is discarded.
- **States:** IDLE, PRIME, READY, PREFETCH, SHIFT.
- **IDLE.** start_prime → PRIME, with the counter cleared. All other commands are ignored.
- **PRIME.**
  - Each acc performs a chain shift with source pix_data and increments cnt.
  - On the acc that makes cnt = ROWS*COLS, go to READY and pulse prime_done.
  - pix_valid low stalls indefinitely.
- **READY.** Commands are evaluated in this priority order:
  1. start_prime → PRIME. Clears cnt and stage_full; stage contents are zeroed.
  2. advance with stage_full=1 → SHIFT, with cnt cleared. advance with stage_full=0 is ignored.
  3. start_prefetch with stage_full=0 → PREFETCH, with cnt cleared. It is ignored if stage_full=1.
- **PREFETCH.**
  - Each acc performs stage[0] <= pix_data and stage[j] <= stage[j-1]. The rows are untouched.
  - On the COLS-th acc: stage_full <= 1, pulse prefetch_done, go to READY.
- **SHIFT.**
  - Runs for exactly COLS cycles, independent of pix_valid.
  - Each cycle: chain shift with source stage[COLS-1], and stage shifts toward COLS-1 with 0 entering stage[0].
  - On the COLS-th cycle: stage_full <= 0, pulse advance_done, go to READY.
- **Commands outside their legal state** (PRIME, PREFETCH, SHIFT) are ignored, not queued.
- **Window packing.**
  - Row r occupies window[(ROWS-1-r)*WIN*PIXEL_W +: WIN*PIXEL_W], so row 0 is most significant.
  - Within a row, line[r][j] for j<WIN sits at bits [j*PIXEL_W +: PIXEL_W].
- **Status outputs.**
  - window_valid = 1 in READY and PREFETCH.
  - busy = 1 in PRIME, PREFETCH and SHIFT.
- **Counter.** cnt width is $clog2(ROWS*COLS+1) and it never wraps.

## Timing
- **Reset.**
  - State becomes IDLE. All line, stage and cnt registers go to 0.
  - Every output is 0, including window.
  - Reset mid-operation aborts immediately; there is no partial-completion pulse.
- **Command latency.** A command sampled at edge N changes state at edge N. pix_ready is first high in cycle N+1.
- **Done pulses.**
  - Each pulse is registered and high exactly one cycle, starting right after the completing edge.
  - window_valid rises in the same cycle as prime_done.
- **Throughput.**
  - Prime takes a minimum of ROWS*COLS cycles.
  - Prefetch takes a minimum of COLS cycles.
  - Advance takes exactly COLS cycles plus one command cycle.
- **Simultaneous commands in READY** follow the priority list above.

## Test plan
Defaults apply throughout: PIXEL_W=24, ROWS=3, COLS=8, WIN=3. Pixel values are given as integers.

- **Prime:** reset, pulse start_prime, stream 1..24 with pix_valid held high.
  - prime_done pulses once, after the 24th accept.
  - window (MSB→LSB) = {22,23,24, 14,15,16, 6,7,8}.
  - window_valid=1, pix_ready=0.
- **Prefetch and advance:** after the prime test, start_prefetch and stream 101..108 → prefetch_done and stage_full=1, window unchanged. Then pulse advance:
  - busy stays high for 8 cycles, then advance_done pulses.
  - window = {106,107,108, 22,23,24, 14,15,16}; stage_full=0.
- **Backpressure:** during prime, deassert pix_valid for 5 random gaps.
  - Result is identical to the prime test.
  - No accept occurs while pix_valid=0.
- **Illegal commands:**
  - advance with stage_full=0 in READY → no state change.
  - start_prefetch while stage_full=1 → ignored.
  - Any command during SHIFT → ignored; SHIFT still takes exactly 8 cycles.
- **Priority:** start_prime and advance in the same READY cycle → PRIME entered, stage_full=0, 24 pixels required.
- **Reset mid-operation:** assert rst after 10 prime accepts.
  - All outputs are 0 and state is IDLE.
  - No prime_done pulse occurs.
  - A fresh prime of 1..24 reproduces the prime-test window.
